// File: rtl/mem_if_pkg.sv
// Shared types and address-range helper for the data-memory initiator and the core LSU.
package mem_if_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_LSB   = 2;
    localparam int unsigned RANGE_W    = 65;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_VERIFY,
        ST_RESP
    } mem_state_e;

    // Operands are zero-extended by the caller so base + bytes cannot wrap.
    function automatic logic addr_in_range(input logic [RANGE_W-1:0] addr,
                                           input logic [RANGE_W-1:0] base,
                                           input logic [RANGE_W-1:0] depth_words);
        logic [RANGE_W-1:0] limit;
        limit = base + depth_words * RANGE_W'(WORD_BYTES);
        return (addr >= base) && (addr < limit);
    endfunction

endpackage

// File: rtl/mem_addr_check.sv
// Combinational legality check for a request byte address: word alignment and
// membership in [BASE_ADDR, BASE_ADDR + 4*MEM_DEPTH).
module mem_addr_check
    import mem_if_pkg::*;
#(
    parameter int unsigned       AWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000,
    parameter int unsigned       MEM_DEPTH = 1024
) (
    input  logic [AWIDTH-1:0] addr_i,
    output logic              misaligned_o,
    output logic              out_of_range_o
);

    assign misaligned_o   = |addr_i[WORD_LSB-1:0];
    assign out_of_range_o = !addr_in_range(RANGE_W'(addr_i), RANGE_W'(BASE_ADDR),
                                           RANGE_W'(MEM_DEPTH));

endmodule

// File: rtl/mem_initiator.sv
// Requester-side master for the word-addressed data memory: one load/store in flight.
// Optional read-back check of stores is enabled by defining MEM_WRITE_VERIFY_EN.
module mem_initiator
    import mem_if_pkg::*;
#(
    parameter int unsigned       AWIDTH    = 32,
    parameter int unsigned       DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000,
    parameter int unsigned       MEM_DEPTH = 1024,
    parameter int unsigned       CNTW      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i,
    input  logic              mem_valid_i,
    output logic [CNTW-1:0]   err_cnt_o
);

    mem_state_e        state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              aerr_q, aerr_d;
    logic              err_q, err_d;
    logic [CNTW-1:0]   err_cnt_q, err_cnt_d;

    logic              misaligned, out_of_range;
    logic              rd_state;
    logic [AWIDTH-1:0] word_idx;

    mem_addr_check #(
        .AWIDTH   (AWIDTH),
        .BASE_ADDR(BASE_ADDR),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_addr_check (
        .addr_i        (req_addr_i),
        .misaligned_o  (misaligned),
        .out_of_range_o(out_of_range)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aerr_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            aerr_q    <= aerr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Illegal addresses pass through the READ slot with strobes masked, which keeps
    // error latency equal to load latency.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        aerr_d    = aerr_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    aerr_d  = misaligned | out_of_range;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = (misaligned || out_of_range || !req_we_i) ? ST_READ : ST_WRITE;
                end
            end
            ST_READ: begin
                rdata_d = (!aerr_q && mem_valid_i) ? mem_data_i : '0;
                err_d   = aerr_q | ~mem_valid_i;
                state_d = ST_RESP;
            end
            ST_WRITE: begin
                rdata_d = '0;
                err_d   = 1'b0;
`ifdef MEM_WRITE_VERIFY_EN
                state_d = ST_VERIFY;
`else
                state_d = ST_RESP;
`endif
            end
`ifdef MEM_WRITE_VERIFY_EN
            ST_VERIFY: begin
                err_d   = ~mem_valid_i | (mem_data_i != wdata_q);
                state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                    if (err_q && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + CNTW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MEM_WRITE_VERIFY_EN
    assign rd_state = (state_q == ST_READ) || (state_q == ST_VERIFY);
`else
    assign rd_state = (state_q == ST_READ);
`endif

    assign word_idx       = (addr_q - BASE_ADDR) >> WORD_LSB;
    assign mem_read_en_o  = rd_state && !aerr_q;
    assign mem_write_en_o = (state_q == ST_WRITE);
    assign mem_addr_o     = (mem_read_en_o || mem_write_en_o) ? word_idx : '0;
    assign mem_data_o     = mem_write_en_o ? wdata_q : '0;

    assign req_ready_o = (state_q == ST_IDLE) && rst;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
    assign rsp_err_o   = rsp_valid_o && err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator: directed scenarios plus random traffic
// against a byte-address reference model; honours MEM_WRITE_VERIFY_EN.
module tb_mem_initiator;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam logic [31:0] BASE  = 32'h01000000;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned CW    = 8;

    logic          clk;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_rd, mem_wr, mem_valid;
    logic [CW-1:0] err_cnt;

    mem_initiator #(
        .AWIDTH   (AW),
        .DWIDTH   (DW),
        .BASE_ADDR(BASE),
        .MEM_DEPTH(DEPTH),
        .CNTW     (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_we_i      (req_we),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .mem_addr_o    (mem_addr),
        .mem_data_o    (mem_wdata),
        .mem_read_en_o (mem_rd),
        .mem_write_en_o(mem_wr),
        .mem_data_i    (mem_rdata),
        .mem_valid_i   (mem_valid),
        .err_cnt_o     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory: combinational read, posedge write, valid only for a
    // lone read strobe inside the array.
    bit [31:0] marr [DEPTH];
    always_comb begin
        mem_valid = mem_rd && !mem_wr && (mem_addr < DEPTH);
        mem_rdata = mem_valid ? marr[mem_addr[9:0]] : '0;
    end
    always @(posedge clk) begin
        if (mem_wr && !mem_rd && (mem_addr < DEPTH)) marr[mem_addr[9:0]] <= mem_wdata;
    end

    // Reference: byte-addressed store contents, and the error counter.
    logic [31:0] ref_mem [int unsigned];
    int          exp_cnt;
    int          n_tests;
    int          n_fail;

    function automatic bit legal(input logic [31:0] a);
        longint unsigned la;
        la = longint'({32'b0, a});
        return (a[1:0] == 2'b00) && (la >= longint'({32'b0, BASE})) &&
               (la < longint'({32'b0, BASE}) + 4 * longint'(DEPTH));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the response handshake.
    task automatic run_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int hold, input bit pulse);
        bit          lg;
        logic [31:0] e_rd;
        int          exp_lat;
        int          n;
        bit          saw_rd, saw_wr, both;
        lg      = legal(addr);
        e_rd    = '0;
        exp_lat = 2;
        if (!we && lg && ref_mem.exists(addr)) e_rd = ref_mem[addr];
        if (we && lg) ref_mem[addr] = wdata;
`ifdef MEM_WRITE_VERIFY_EN
        if (we && lg) exp_lat = 3;
`endif
        check("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0; req_we = $urandom_range(0, 1);
        req_addr  = $urandom; req_wdata = $urandom;
        saw_rd = 1'b0; saw_wr = 1'b0; both = 1'b0;
        for (n = 1; n <= 8; n++) begin
            saw_rd |= mem_rd;
            saw_wr |= mem_wr;
            both   |= mem_rd & mem_wr;
            if (rsp_valid) break;
            check("req_ready_busy", 64'(req_ready), 64'(0));
            @(negedge clk);
        end
        check("latency", 64'(n), 64'(exp_lat));
`ifdef MEM_WRITE_VERIFY_EN
        check("saw_read_en", 64'(saw_rd), 64'(lg));
`else
        check("saw_read_en", 64'(saw_rd), 64'(lg && !we));
`endif
        check("saw_write_en", 64'(saw_wr), 64'(lg && we));
        check("strobes_exclusive", 64'(both), 64'(0));
        check("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
        check("rsp_err", 64'(rsp_err), 64'(!lg));
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == 1) begin
                req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h10; req_wdata = 32'ha5a5a5a5;
            end
            @(negedge clk);
            req_valid = 1'b0;
            check("hold_valid", 64'(rsp_valid), 64'(1));
            check("hold_rdata", 64'(rsp_rdata), 64'(e_rd));
            check("hold_err", 64'(rsp_err), 64'(!lg));
            check("hold_req_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (!lg && exp_cnt < 255) exp_cnt++;
        check("rsp_valid_after_hs", 64'(rsp_valid), 64'(0));
        check("req_ready_after_hs", 64'(req_ready), 64'(1));
        check("err_cnt", 64'(err_cnt), 64'(exp_cnt));
    endtask

    initial begin
        logic [31:0] a;
        int          n;
        n_tests = 0; n_fail = 0; exp_cnt = 0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_mem_rd", 64'(mem_rd), 64'(0));
        check("rst_mem_wr", 64'(mem_wr), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_data", 64'(mem_wdata), 64'(0));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_req(1'b1, 32'h01000000, 32'hdeadbeef, 0, 1'b0);
        run_req(1'b0, 32'h01000000, 32'h0, 0, 1'b0);
        run_req(1'b1, 32'h01000ffc, 32'h01100110, 0, 1'b0);
        run_req(1'b0, 32'h01000ffc, 32'h0, 0, 1'b0);
        run_req(1'b0, 32'h01001000, 32'h0, 0, 1'b0);
        run_req(1'b0, 32'h01000002, 32'h0, 0, 1'b0);
        run_req(1'b0, 32'h01000000, 32'h0, 0, 1'b0);
        run_req(1'b0, 32'h01000ffc, 32'h0, 3, 1'b1);
        run_req(1'b0, 32'h01000010, 32'h0, 0, 1'b0);
        run_req(1'b1, 32'h00fffffc, 32'h12345678, 0, 1'b0);

        // Reset asserted while the load is in its READ cycle.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h01000000;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_read_en", 64'(mem_rd), 64'(1));
        rst = 1'b0;
        #1;
        check("midrst_read_en", 64'(mem_rd), 64'(0));
        check("midrst_mem_addr", 64'(mem_addr), 64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        rst = 1'b1;
        exp_cnt = 0;
        #1;
        check("post_rst_req_ready", 64'(req_ready), 64'(1));
        check("post_rst_err_cnt", 64'(err_cnt), 64'(0));
        @(negedge clk);
        check("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
        run_req(1'b1, 32'h01000020, 32'hcafef00d, 0, 1'b0);
        run_req(1'b0, 32'h01000020, 32'h0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    a = BASE + 32'(4 * $urandom_range(0, 15));
                2:       a = BASE + 32'(4 * $urandom_range(1008, 1023));
                3:       a = BASE + 32'($urandom_range(0, 63));
                default: a = (($urandom & 1) != 0) ? BASE + 32'h1000 + 32'(4 * $urandom_range(0, 3))
                                                   : $urandom;
            endcase
            run_req(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)), 1'b0);
        end

        // Drive the error counter into saturation.
        n = 0;
        while (exp_cnt < 255 && n < 300) begin
            run_req(1'b0, 32'h01000001, 32'h0, 0, 1'b0);
            n++;
        end
        run_req(1'b1, 32'h02000000, 32'h0, 0, 1'b0);
        check("err_cnt_saturated", 64'(err_cnt), 64'(255));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
